// File: rtl/whack_scorer.sv
// whack_scorer: hit/miss scoring, game timer and IDLE/PLAY/OVER game state
// for the whack-a-LED game. Sits downstream of the LED flick stage.
//
// Optional build macro:
//   WHACK_PENALTY_EN - pressing an unlit button while playing costs one point
//                      per cycle, floored at 0. A lit-button press in the same
//                      cycle still scores, so the net change is zero. When the
//                      macro is undefined, wrong presses are ignored.

// Per-button front end: polarity normalize, 2-flop synchronizer, edge detect.
module whack_btn_sync #(
   parameter int BTN_ACTIVE_LOW = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic press
);
   localparam logic POL = (BTN_ACTIVE_LOW != 0);

   logic s1, s2, s3;

   // s1/s2 are the synchronizer; s3 remembers the previous synced level
   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= btn_raw ^ POL;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // One-cycle pulse per press; a held button never re-fires
   assign press = s2 & ~s3;
endmodule

module whack_scorer #(
   parameter int SCORE_MAX      = 99,
   parameter int BTN_ACTIVE_LOW = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [27:0] game_time,
   input  logic [8:0]  lights,
   input  logic [3:0]  position,
   input  logic [8:0]  buttons,
   output logic [7:0]  score,
   output logic [7:0]  misses,
   output logic        hit,
   output logic        miss,
   output logic        playing,
   output logic        game_over,
   output logic [27:0] time_left
);
   localparam int         NUM_BTN = 9;
   localparam logic [7:0] SMAX    = 8'(SCORE_MAX);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_OVER = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [NUM_BTN-1:0]    press;
   logic                  start_d;
   logic                  lit_d;
   logic                  flick_armed;
   logic                  start_edge;
   logic                  lit, lit_rise, lit_fall;
   logic                  in_play;
   logic [NUM_BTN-1:0]    pos_mask;
   logic                  hit_cond, miss_cond;
`ifdef WHACK_PENALTY_EN
   logic                  wrong_press;
`endif

   // One synchronizer/edge-detector per player button
   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      whack_btn_sync #(.BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)) u_sync (
         .clk     (clk),
         .reset   (reset),
         .btn_raw (buttons[i]),
         .press   (press[i])
      );
   end

   assign start_edge = start & ~start_d;
   assign lit        = |lights;
   assign lit_rise   = lit & ~lit_d;
   assign lit_fall   = ~lit & lit_d;

   // A restart edge takes over the cycle; scoring resumes the cycle after
   assign in_play    = (state_q == S_PLAY) && !start_edge;

   // Positions 9-15 select nothing, so they can never score
   assign pos_mask   = (position <= 4'd8) ? (9'h001 << position) : '0;

   assign hit_cond   = in_play && flick_armed && |(pos_mask & lights & press);
   assign miss_cond  = in_play && flick_armed && lit_fall;
`ifdef WHACK_PENALTY_EN
   assign wrong_press = |(press & ~lights);
`endif

   assign playing    = (state_q == S_PLAY);
   assign game_over  = (state_q == S_OVER);

   // Game state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state: start edges enter/restart PLAY, timer expiry ends it
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start_edge) state_d = S_PLAY;
         S_PLAY:  if (!start_edge && time_left == '0) state_d = S_OVER;
         S_OVER:  if (start_edge) state_d = S_PLAY;
         default: state_d = S_IDLE;
      endcase
   end

   // Edge-detect history for start and the lit indicator
   always_ff @(posedge clk) begin
      if (reset) begin
         start_d <= 1'b0;
         lit_d   <= 1'b0;
      end else begin
         start_d <= start;
         lit_d   <= lit;
      end
   end

   // Game timer: load on start edge, count down while playing, 0 elsewhere
   always_ff @(posedge clk) begin
      if (reset)
         time_left <= '0;
      else if (start_edge)
         time_left <= game_time;
      else if (state_q == S_PLAY && time_left != '0)
         time_left <= time_left - 28'd1;
      else if (state_q != S_PLAY)
         time_left <= '0;
   end

   // A flick is armed only by a rise seen during PLAY; it dies on hit, miss,
   // restart, or the game leaving PLAY (no miss for a flick cut off by time)
   always_ff @(posedge clk) begin
      if (reset)
         flick_armed <= 1'b0;
      else if (start_edge || state_d != S_PLAY)
         flick_armed <= 1'b0;
      else if (hit_cond || miss_cond)
         flick_armed <= 1'b0;
      else if (lit_rise)
         flick_armed <= 1'b1;
   end

   // Score and miss counters, saturating at SCORE_MAX (and at 0 on penalty)
   always_ff @(posedge clk) begin
      if (reset) begin
         score  <= '0;
         misses <= '0;
      end else if (start_edge) begin
         score  <= '0;
         misses <= '0;
      end else if (state_q == S_PLAY) begin
`ifdef WHACK_PENALTY_EN
         if (hit_cond && !wrong_press) begin
            if (score < SMAX) score <= score + 8'd1;
         end else if (!hit_cond && wrong_press && score != 8'd0) begin
            score <= score - 8'd1;
         end
`else
         if (hit_cond && score < SMAX) score <= score + 8'd1;
`endif
         if (miss_cond && misses < SMAX) misses <= misses + 8'd1;
      end
   end

   // Result pulses, one cycle after the deciding edge; mutually exclusive
   // since a fall needs lights == 0 and a hit needs a lit bit
   always_ff @(posedge clk) begin
      if (reset) begin
         hit  <= 1'b0;
         miss <= 1'b0;
      end else begin
         hit  <= hit_cond;
         miss <= miss_cond;
      end
   end
endmodule

// File: doc/whack_scorer.md
Name: whack_scorer

Overview:
- Downstream consumer of the LED flick stage.
- Takes the lit-LED vector and the lit position, plus the nine player push-buttons.
- Decides per flick whether the player hit or missed, and keeps score and miss counts.
- Runs the game timer and the IDLE/PLAY/OVER game state that gates scoring; feeds the HEX display and top-level game logic.

Parameters:
SCORE_MAX, 99, saturation value for score and misses (must be <= 255)
BTN_ACTIVE_LOW, 1, 1 = buttons read 0 when pressed (board keys); 0 = active-high

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle-or-longer start/restart request (level, edge-detected internally)
game_time  input  28  game length in clk cycles, sampled on start
lights  input  9  one-hot (or zero) lit-LED vector from flick stage
position  input  4  index 0-8 of lit LED; values 9-15 never match
buttons  input  9  raw player buttons, asynchronous
score  output  8  hits this game, binary, saturating
misses  output  8  missed flicks this game, binary, saturating
hit  output  1  one-cycle pulse on a scored hit
miss  output  1  one-cycle pulse on a missed flick
playing  output  1  high in PLAY
game_over  output  1  high in OVER
time_left  output  28  remaining cycles in PLAY; 0 otherwise

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - State IDLE.
  - score, misses, hit, miss, playing, game_over and time_left all 0.
  - Synchronizers and edge registers all cleared.
  - flick_armed = 0.
- Button path:
  - Normalize polarity per BTN_ACTIVE_LOW.
  - 2-flop synchronizer, then a third register for edge detection: press[i] = s2[i] & ~s3[i].
  - A press is visible 2 clk after the raw edge; held buttons produce exactly one press.
- start is edge-detected (start & ~start_d); a held start counts once.
- FSM:
  - IDLE: on start edge -> PLAY. Same edge clears score and misses and loads time_left = game_time.
  - PLAY:
    - time_left decrements by 1 each cycle.
    - When time_left == 0 at a clock edge -> OVER.
    - game_time = 0 gives exactly one PLAY cycle.
    - A start edge in PLAY restarts: clear counts, reload the timer, stay in PLAY.
  - OVER: counts hold; time_left = 0; start edge -> PLAY as from IDLE.
- Flick tracking (PLAY only):
  - lit = |lights, with lit_d registered.
  - Rising edge of lit (lit & ~lit_d) sets flick_armed = 1.
- Hit rule:
  - Condition: PLAY, flick_armed, position <= 8, lights[position] = 1 and press[position] = 1 in the same cycle.
  - Effect: score += 1 (saturate at SCORE_MAX), hit pulses next cycle, flick_armed cleared.
  - One hit max per flick; extra presses ignored.
  - Other buttons pressed in the same cycle do not cancel the hit.
- Miss rule:
  - Condition: falling edge of lit (~lit & lit_d) while flick_armed = 1 in PLAY.
  - Effect: misses += 1 (saturate), miss pulses next cycle, flick_armed cleared.
- Boundaries:
  - Hit and fall cannot coincide, because a fall requires lights == 0.
  - Leaving PLAY clears flick_armed; no miss is counted for a flick cut off by the game end.
  - A flick already lit when PLAY begins is not armed; only flicks rising during PLAY count.
  - hit and miss are never high together.
- Latency: raw button edge to hit pulse = 3 clk. Fall of lights to miss pulse = 1 clk.

Optional Feature:
- Macro: WHACK_PENALTY_EN.
- When defined: in PLAY, any press on a button whose bit is not currently lit decrements score by 1 per cycle in which one or more such presses occur, saturating at 0. A press on the lit button in the same cycle still scores: net 0 change, hit still pulses.
- When not defined: wrong presses are ignored and score never decrements.

Test Plan:
- Reset then start edge with game_time=1000 -> playing=1, score=0, misses=0, time_left=1000; OVER after 1001 cycles with game_over=1, time_left=0.
- Light position 4 (lights=9'h010), press button 4 during flick -> hit pulse 3 clk after raw press, score=1; second press same flick -> score stays 1.
- Light position 2 for 50 cycles with no press -> miss pulse 1 clk after lights=0, misses=1, score unchanged.
- Hold button 7 pressed across two flicks at position 7 -> only one press, score=1, then misses=1 for second flick.
- Drive 100 hits with SCORE_MAX=99 -> score saturates at 99; restart via start edge in PLAY -> score=0, time_left reloaded.
- WHACK_PENALTY_EN: score=3, lights=9'h001, press button 5 -> score=2; from score=0 wrong press -> score=0; assert reset mid-game -> all outputs 0, IDLE.
